// File: rtl/uart_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : uart_word_packer
// Brief    : Avalon-MM master that polls the RS232 UART status register,
//            reads RX bytes and packs them into BYTES_PER_WORD-byte words.
// Revision : 1.0 - initial release
// ============================================================================
module uart_word_packer #(
    parameter int BYTES_PER_WORD = 3,
    parameter int MSB_FIRST      = 1,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int FRAME_WORDS    = 640*480,
    parameter int RX_BASE        = 0,
    parameter int STATUS_BASE    = 8,
    parameter int RX_OK_BIT      = 7
) (
    input  logic                        avm_clk,
    input  logic                        avm_rst_n,
    output logic [4:0]                  avm_address,
    output logic                        avm_read,
    input  logic [31:0]                 avm_readdata,
    input  logic                        avm_waitrequest,
    output logic [8*BYTES_PER_WORD-1:0] o_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_frame_done,
    output logic                        o_drop
);

    localparam int c_cnt_w   = $clog2(BYTES_PER_WORD + 1);
    localparam int c_frame_w = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int c_idle_w  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [c_cnt_w-1:0]   c_cnt_last    = c_cnt_w'(BYTES_PER_WORD - 1);
    localparam logic [c_frame_w-1:0] c_frame_last  = c_frame_w'(FRAME_WORDS - 1);
    localparam logic [4:0]           c_status_addr = 5'(STATUS_BASE);
    localparam logic [4:0]           c_rx_addr     = 5'(RX_BASE);

    localparam logic [1:0] S_POLL = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]                  r_state;
    logic [4:0]                  r_address;
    logic                        r_read;
    logic [c_cnt_w-1:0]          r_cnt;
    logic [8*BYTES_PER_WORD-1:0] r_data;
    logic                        r_valid;
    logic [c_frame_w-1:0]        r_frame_cnt;
    logic                        r_frame_done;
    logic                        r_drop;

    logic                        w_xfer;
    logic                        w_rx_done;
    logic                        w_handshake;
    logic                        w_counting;
    logic                        w_timeout;
    logic [BYTES_PER_WORD-1:0]   w_byte_we;
    logic                        w_unused_ok;

    assign w_xfer      = r_read && !avm_waitrequest;
    assign w_rx_done   = w_xfer && (r_state == S_READ);
    assign w_handshake = r_valid && i_ready;
    assign w_counting  = (r_cnt != '0) && (r_state != S_HOLD);
    assign w_unused_ok = ^{avm_readdata, w_counting};

    // Byte slot selected by the running byte count and the configured order.
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_byte
        localparam int c_slot = (MSB_FIRST != 0) ? (BYTES_PER_WORD - 1 - gi) : gi;
        assign w_byte_we[gi] = w_rx_done && (r_cnt == c_cnt_w'(c_slot));
    end

    if (TIMEOUT_CYCLES > 0) begin : g_timeout
        localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(TIMEOUT_CYCLES - 1);
        logic [c_idle_w-1:0] r_idle;

        always_ff @(posedge avm_clk) begin
            if (!avm_rst_n || w_rx_done || !w_counting || w_timeout) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + 1'b1;
            end
        end

        // A byte landing in the same cycle takes priority over the discard.
        assign w_timeout = w_counting && !w_rx_done && (r_idle == c_idle_last);
    end else begin : g_no_timeout
        assign w_timeout = 1'b0;
    end

    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) begin
            r_state   <= S_POLL;
            r_address <= c_status_addr;
            r_read    <= 1'b0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_drop <= w_timeout;
            if (w_timeout) begin
                r_cnt <= '0;
            end
            case (r_state)
                S_POLL: begin
                    if (w_xfer) begin
                        r_read <= 1'b0;
                        if (avm_readdata[RX_OK_BIT]) begin
                            r_state   <= S_READ;
                            r_address <= c_rx_addr;
                        end
                    end else if (!r_read) begin
                        r_read <= 1'b1;
                    end
                end
                S_READ: begin
                    if (w_xfer) begin
                        r_read    <= 1'b0;
                        r_address <= c_status_addr;
                        if (r_cnt == c_cnt_last) begin
                            r_cnt   <= '0;
                            r_state <= S_HOLD;
                            r_valid <= 1'b1;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= S_POLL;
                        end
                    end else if (!r_read) begin
                        r_read <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // No UART traffic while a word waits; the UART FIFO absorbs backpressure.
                    if (w_handshake) begin
                        r_valid <= 1'b0;
                        r_state <= S_POLL;
                    end
                end
                default: begin
                    r_state   <= S_POLL;
                    r_address <= c_status_addr;
                    r_read    <= 1'b0;
                    r_valid   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) begin
            r_data <= '0;
        end else if (w_timeout) begin
            r_data <= '0;
        end else begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (w_byte_we[i]) begin
                    r_data[8*i +: 8] <= avm_readdata[7:0];
                end
            end
        end
    end

    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) begin
            r_frame_cnt  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_handshake) begin
                if (r_frame_cnt == c_frame_last) begin
                    r_frame_cnt  <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    assign avm_address  = r_address;
    assign avm_read     = r_read;
    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_frame_done = r_frame_done;
    assign o_drop       = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_uart_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_word_packer
// Brief    : Self-checking bench; the bench plays the UART Avalon slave for
//            two packer configurations (3-byte MSB-first, 4-byte LSB-first).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_word_packer;

    localparam logic [4:0] c_status = 5'd8;
    localparam logic [4:0] c_rx     = 5'd0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        wreq;
    logic [31:0] rdata;
    logic        ready;
    int          cyc = 0;

    logic [4:0]  a_addr, b_addr;
    logic        a_read, b_read;
    logic [23:0] a_data;
    logic [31:0] b_data;
    logic        a_valid, b_valid, a_fd, b_fd, a_drop, b_drop;

    logic [4:0]  cur_addr;
    logic        cur_read, cur_valid, cur_fd, cur_drop;
    logic [31:0] cur_data;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          last_done = 0;
    int          hs_cnt[2];
    logic [7:0]  model_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_word_packer #(
        .BYTES_PER_WORD(3), .MSB_FIRST(1), .TIMEOUT_CYCLES(16), .FRAME_WORDS(4),
        .RX_BASE(0), .STATUS_BASE(8), .RX_OK_BIT(7)
    ) u_dut_a (
        .avm_clk(clk), .avm_rst_n(rst_n), .avm_address(a_addr), .avm_read(a_read),
        .avm_readdata(rdata), .avm_waitrequest(sel ? 1'b1 : wreq),
        .o_data(a_data), .o_valid(a_valid), .i_ready(sel ? 1'b0 : ready),
        .o_frame_done(a_fd), .o_drop(a_drop)
    );

    uart_word_packer #(
        .BYTES_PER_WORD(4), .MSB_FIRST(0), .TIMEOUT_CYCLES(0),
        .RX_BASE(0), .STATUS_BASE(8), .RX_OK_BIT(7)
    ) u_dut_b (
        .avm_clk(clk), .avm_rst_n(rst_n), .avm_address(b_addr), .avm_read(b_read),
        .avm_readdata(rdata), .avm_waitrequest(sel ? wreq : 1'b1),
        .o_data(b_data), .o_valid(b_valid), .i_ready(sel ? ready : 1'b0),
        .o_frame_done(b_fd), .o_drop(b_drop)
    );

    always_comb begin
        cur_addr  = a_addr;
        cur_read  = a_read;
        cur_valid = a_valid;
        cur_data  = {8'h00, a_data};
        cur_fd    = a_fd;
        cur_drop  = a_drop;
        if (sel) begin
            cur_addr  = b_addr;
            cur_read  = b_read;
            cur_valid = b_valid;
            cur_data  = b_data;
            cur_fd    = b_fd;
            cur_drop  = b_drop;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Serve one Avalon read: wait for the strobe, stall, then return data.
    task automatic do_access(input logic [4:0] exp_addr, input logic [4:0] next_addr,
                             input int stall, input logic [31:0] data, input bit quick);
        int n = 0;
        bit stable = 1'b1;
        while (cur_read !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("read_asserted", 32'(cur_read), 32'd1);
        if (quick) check("gap_length", n, 32'd1);
        check("address", 32'(cur_addr), 32'(exp_addr));
        wreq = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (cur_read !== 1'b1 || cur_addr !== exp_addr) stable = 1'b0;
        end
        if (stall > 0) check("stall_hold", 32'(stable), 32'd1);
        rdata = data;
        wreq  = 1'b0;
        @(posedge clk); #1;
        wreq  = 1'b1;
        rdata = 32'h0;
        last_done = cyc;
        check("gap_read_low", 32'(cur_read), 32'd0);
        check("gap_address", 32'(cur_addr), 32'(next_addr));
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall, input int polls, input bit first_quick);
        for (int p = 0; p < polls; p++)
            do_access(c_status, c_status, stall, 32'h5A5A_FF7F, (p == 0) ? first_quick : 1'b1);
        do_access(c_status, c_rx, stall, 32'h0000_0080, (polls == 0) ? first_quick : 1'b1);
        do_access(c_rx, c_status, stall, {24'hA5C3E1, b}, 1'b1);
    endtask

    task automatic send_word(input logic dut, input logic [31:0] bytes, input int stall,
                             input int polls, input int rdelay, input logic [31:0] exp);
        int   nb = dut ? 4 : 3;
        int   prev = 0;
        bit   stable = 1'b1;
        logic exp_fd;
        sel = dut;
        for (int i = 0; i < nb; i++) begin
            send_byte(bytes[8*i +: 8], stall, polls, i > 0);
            if (i > 0 && stall == 0 && polls == 0) check("byte_spacing", last_done - prev, 32'd4);
            prev = last_done;
        end
        check("valid_after_last_byte", 32'(cur_valid), 32'd1);
        check("word_data", cur_data, exp);
        for (int k = 0; k < rdelay; k++) begin
            @(posedge clk); #1;
            if (cur_valid !== 1'b1 || cur_data !== exp || cur_read !== 1'b0) stable = 1'b0;
        end
        if (rdelay > 0) check("backpressure_hold", 32'(stable), 32'd1);
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        hs_cnt[dut]++;
        exp_fd = (dut == 1'b0) && (hs_cnt[0] % 4 == 0);
        check("valid_low_after_hs", 32'(cur_valid), 32'd0);
        check("read_low_after_hs", 32'(cur_read), 32'd0);
        check("frame_done", 32'(cur_fd), 32'(exp_fd));
        @(posedge clk); #1;
        check("poll_resume", 32'({cur_read, cur_addr}), 32'({1'b1, c_status}));
        check("frame_done_width", 32'(cur_fd), 32'd0);
    endtask

    // Reference packing: bytes in arrival order, assembled arithmetically.
    function automatic logic [31:0] model_word(input logic dut);
        logic [31:0] w = 32'h0;
        int nb = dut ? 4 : 3;
        for (int i = 0; i < nb; i++) begin
            if (!dut) w = (w << 8) | 32'(model_q[i]);
            else      w = w | (32'(model_q[i]) << (8 * i));
        end
        repeat (nb) void'(model_q.pop_front());
        return w;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_address"}, 32'(cur_addr), 32'(c_status));
        check({tag, "_read"}, 32'(cur_read), 32'd0);
        check({tag, "_data"}, cur_data, 32'd0);
        check({tag, "_valid"}, 32'(cur_valid), 32'd0);
        check({tag, "_frame_done"}, 32'(cur_fd), 32'd0);
        check({tag, "_drop"}, 32'(cur_drop), 32'd0);
    endtask

    typedef struct {
        logic        dut;
        logic [7:0]  b0, b1, b2, b3;
        int          stall;
        int          polls;
        int          rdelay;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   first_drop;
        int   drop_cycles;

        vecs[0] = '{1'b0, 8'h12, 8'h34, 8'h56, 8'h00, 0, 0, 0,  32'h0012_3456};
        vecs[1] = '{1'b1, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 0, 0, 0,  32'hDDCC_BBAA};
        vecs[2] = '{1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 5, 10, 0, 32'h4433_2211};
        vecs[3] = '{1'b0, 8'hA1, 8'hB2, 8'hC3, 8'h00, 0, 0, 20, 32'h00A1_B2C3};
        vecs[4] = '{1'b0, 8'hFF, 8'h00, 8'h80, 8'h00, 2, 1, 3,  32'h00FF_0080};
        vecs[5] = '{1'b0, 8'h01, 8'h02, 8'h03, 8'h00, 1, 0, 1,  32'h0001_0203};

        rst_n = 1'b0; sel = 1'b0; wreq = 1'b1; rdata = 32'h0; ready = 1'b0;
        hs_cnt[0] = 0; hs_cnt[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("read_after_reset", 32'(cur_read), 32'd1);

        for (int v = 0; v < 6; v++)
            send_word(vecs[v].dut, {vecs[v].b3, vecs[v].b2, vecs[v].b1, vecs[v].b0},
                      vecs[v].stall, vecs[v].polls, vecs[v].rdelay, vecs[v].exp);

        // Reset with one byte of a word already taken and a status read in flight.
        sel = 1'b0;
        send_byte(8'h5A, 0, 0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_state("midword_reset");
        rst_n = 1'b1;
        hs_cnt[0] = 0; hs_cnt[1] = 0;
        @(posedge clk); #1;
        check("read_after_midword_reset", 32'(cur_read), 32'd1);
        send_word(1'b0, 32'h00EE_FFC0, 0, 0, 0, 32'h00C0_FFEE);

        // Two bytes then silence: the partial word is dropped after 16 idle cycles.
        sel = 1'b0;
        send_byte(8'h77, 0, 0, 1'b0);
        send_byte(8'h88, 0, 0, 1'b1);
        first_drop = -1;
        drop_cycles = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (cur_drop === 1'b1) begin
                if (first_drop < 0) first_drop = k;
                drop_cycles++;
            end
        end
        check("drop_delay", first_drop, 32'd16);
        check("drop_width", drop_cycles, 32'd1);
        check("no_valid_after_drop", 32'(cur_valid), 32'd0);
        send_word(1'b0, 32'h0003_0201, 0, 0, 0, 32'h0001_0203);

        for (int r = 0; r < 16; r++) begin
            logic        d;
            logic [31:0] bytes;
            int          nb, st, pl;
            d     = ($urandom_range(0, 1) == 1);
            nb    = d ? 4 : 3;
            st    = d ? $urandom_range(0, 6) : $urandom_range(0, 2);
            pl    = d ? $urandom_range(0, 4) : $urandom_range(0, 1);
            bytes = $urandom;
            for (int i = 0; i < nb; i++) model_q.push_back(bytes[8*i +: 8]);
            send_word(d, bytes, st, pl, $urandom_range(0, 5), model_word(d));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/uart_word_packer.md
# uart_word_packer

Parametrised Avalon-MM master that polls the RS232 UART core's status register, reads received bytes one at a time, and packs them into `BYTES_PER_WORD`-byte words. It is the successor to the fixed 3-byte pixel loader. It adds:

- configurable word width and byte order
- a valid/ready output handshake with backpressure
- an inter-byte timeout that resynchronises after dropped bytes
- a frame word counter with an end-of-frame pulse

It sits between the UART Avalon slave and the image/frame-buffer writer.

## Interface
Parameters:
- `BYTES_PER_WORD`, 3: bytes packed per output word (1..4).
- `MSB_FIRST`, 1: 1 = first received byte lands in the top byte of `o_data`; 0 = first byte lands in `o_data[7:0]`.
- `TIMEOUT_CYCLES`, 0: number of idle cycles with a partial word before that word is discarded; 0 disables the timeout.
- `FRAME_WORDS`, 640*480: number of words per frame for `o_frame_done`.
- `RX_BASE`, 0: byte address of the RX data register.
- `STATUS_BASE`, 8: byte address of the status register.
- `RX_OK_BIT`, 7: status bit meaning "RX byte available".

Ports:
- `avm_clk` in 1: the single clock.
- `avm_rst_n` in 1: reset, synchronous and active-low.
- `avm_address` out 5: Avalon address.
- `avm_read` out 1: Avalon read strobe.
- `avm_readdata` in 32: Avalon read data; only bits [7:0] and `RX_OK_BIT` are used.
- `avm_waitrequest` in 1: Avalon stall.
- `o_data` out 8*BYTES_PER_WORD: packed word.
- `o_valid` out 1: word available.
- `i_ready` in 1: consumer accepts the word.
- `o_frame_done` out 1: one-cycle pulse after the last word of a frame is accepted.
- `o_drop` out 1: one-cycle pulse when a partial word is discarded by the timeout.

## Operation
A transfer completes in any cycle where `avm_read=1` and `avm_waitrequest=0`. All outputs are registered.

States:
- **S_POLL**
  - Drive `avm_address=STATUS_BASE`, `avm_read=1`.
  - On a completed transfer with `avm_readdata[RX_OK_BIT]=1`: go to S_READ.
  - Otherwise keep polling back-to-back.
- **S_READ**
  - Drive `avm_address=RX_BASE`, `avm_read=1`.
  - On a completed transfer, store `avm_readdata[7:0]` at byte index `cnt` and increment `cnt`:
    - MSB_FIRST=1: slot `BYTES_PER_WORD-1-cnt`.
    - MSB_FIRST=0: slot `cnt`.
  - If `cnt` was `BYTES_PER_WORD-1`: set `cnt=0`, go to S_HOLD.
  - Otherwise go to S_POLL.
- **S_HOLD**
  - `avm_read=0`; `o_valid=1`; `o_data` is stable.
  - When `i_ready=1`: go to S_POLL.
  - No UART reads are issued while a word is waiting, so backpressure stalls the UART FIFO rather than losing data.

Gap rule:
- After every completed transfer, `avm_read` is 0 for exactly one cycle.
- The new address is presented in that gap cycle.
- `avm_read` reasserts in the following cycle.

Timeout (`TIMEOUT_CYCLES>0`):
- An idle counter resets on every completed RX byte read and counts while `cnt>0` and state is not S_HOLD.
- When it reaches `TIMEOUT_CYCLES`:
  - set `cnt=0` and clear the partial bytes;
  - pulse `o_drop` for 1 cycle;
  - any transfer in flight continues normally.
- If the timeout and a byte completion coincide, the byte wins and the counter clears.

Frame counter:
- Increments on each handshake (`o_valid && i_ready`).
- On the handshake of word `FRAME_WORDS-1`: wrap to 0 and pulse `o_frame_done` in the next cycle.

Widths:
- `cnt` is `$clog2(BYTES_PER_WORD+1)` bits.
- The frame counter is `$clog2(FRAME_WORDS)` bits.
- The idle counter is `$clog2(TIMEOUT_CYCLES+1)` bits.

## Timing
Reset values (`avm_rst_n=0` at a clock edge), applied on the next edge from any state, including mid-transfer or mid-word:
- state S_POLL
- `avm_address=STATUS_BASE`, `avm_read=0`
- `o_data=0`, `o_valid=0`, `o_frame_done=0`, `o_drop=0`
- all counters 0

After reset:
- `avm_read` rises on the first clock edge after reset is released.
- A partial word is lost on reset; there is no recovery.

Latency:
- The final byte completes at edge N; `o_valid=1` from edge N+1.
- `o_valid` falls the cycle after the handshake.
- The next status read begins the cycle after that (the gap rule applies).

Throughput:
- Minimum 4 cycles per byte (status read, gap, RX read, gap) with `waitrequest=0`.
- Each word adds at least one S_HOLD cycle.

`avm_waitrequest` held high: `avm_address` and `avm_read` stay constant; no state change.

## Test plan
- **Pack, MSB first.** BYTES=3, MSB_FIRST=1, bytes 0x12, 0x34, 0x56 with RX_OK=1 → `o_data=0x123456`, `o_valid` for 1 cycle with `i_ready=1`. Check 4-cycle byte spacing and read-gap cycles.
- **Byte order.** MSB_FIRST=0, BYTES=4, bytes 0xAA, 0xBB, 0xCC, 0xDD → `o_data=0xDDCCBBAA`.
- **Waitrequest and empty polling.** `waitrequest` high for 5 cycles on each access, RX_OK=0 for 10 polls → address/read stable while stalled, no RX reads before RX_OK=1, correct word afterwards.
- **Backpressure.** `i_ready=0` for 20 cycles → `o_valid` held, `o_data` stable, `avm_read=0` throughout; after `i_ready=1`, polling resumes 1 cycle later.
- **Timeout.** TIMEOUT_CYCLES=16: send 2 bytes then nothing → `o_drop` pulse 16 cycles after the 2nd byte. Then 0x01, 0x02, 0x03 → `o_data=0x010203`.
- **Frame and reset.** FRAME_WORDS=4, 4 words → `o_frame_done` one cycle after the 4th handshake, counter wraps. Assert reset after 1 byte of the next word → all outputs return to reset values; the next 3 bytes form a clean word.
